// File: rtl/rnn_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// rnn_mem_arbiter_if
// Bundles both requester ports and the memory macro port of the RNN memory
// arbiter.
//
// Handshake: a requester raises reqN and holds it, with selN/addrN/wdataN,
// until it sees gntN. Every cycle in which both reqN and gntN are high is
// exactly one memory access (mce=1). A requester may change its
// sel/addr/wdata on every granted cycle. A read access returns its data on
// rdataN one cycle later, qualified by rvalidN. A write access (selN equal to
// the write select code) produces no rvalid. gntN can drop on any edge, so a
// requester must keep reqN high until it is granted again.
//
// Modports:
//   master : requesters plus the memory macro (drive req/lock/sel/addr/wdata
//            and mdata_r, observe grants, read returns and the memory bus)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface rnn_mem_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 20,
  parameter int SW = 3
);
  // port 0: RNN compute core
  logic          req0;
  logic          lock0;
  logic [SW-1:0] sel0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic [DW-1:0] rdata0;
  logic          rvalid0;
  // port 1: host load/readback engine
  logic          req1;
  logic          lock1;
  logic [SW-1:0] sel1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic [DW-1:0] rdata1;
  logic          rvalid1;
  // memory macro
  logic          mce;
  logic [AW-1:0] maddr;
  logic [SW-1:0] msel;
  logic [DW-1:0] mdata_w;
  logic [DW-1:0] mdata_r;

  modport slave (
    input  req0, lock0, sel0, addr0, wdata0,
    input  req1, lock1, sel1, addr1, wdata1,
    input  mdata_r,
    output gnt0, rdata0, rvalid0,
    output gnt1, rdata1, rvalid1,
    output mce, maddr, msel, mdata_w
  );

  modport master (
    output req0, lock0, sel0, addr0, wdata0,
    output req1, lock1, sel1, addr1, wdata1,
    output mdata_r,
    input  gnt0, rdata0, rvalid0,
    input  gnt1, rdata1, rvalid1,
    input  mce, maddr, msel, mdata_w
  );
endinterface

// File: rtl/rnn_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rnn_mem_arbiter
// Shares the single RNN memory port between the compute core (port 0) and
// the host load/readback engine (port 1). Round-robin on ties, burst locking
// with a starvation cap, and read-return routing to the port that issued
// the read.
//
// Ports:
//   clk       clock, all state on the rising edge
//   reset     asynchronous, active-low reset
//   bus       rnn_mem_arbiter_if.slave: both requester ports + memory port
//   dbg_state current FSM state (0=IDLE, 1=OWN0, 2=OWN1)
// ---------------------------------------------------------------------------
module rnn_mem_arbiter #(
  parameter int            AW       = 17,
  parameter int            DW       = 20,
  parameter int            SW       = 3,
  parameter logic [SW-1:0] WR_SEL   = 3'b101,
  parameter int            MAX_HOLD = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  rnn_mem_arbiter_if.slave      bus,
  output logic [1:0]            dbg_state
);

  localparam int            HW       = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;      // last owner; the other port wins a tie
  logic [HW-1:0] hold_cnt;  // access cycles spent in the current state
  logic          rd_pend;   // a read was issued in the previous cycle
  logic          rd_tag;    // port that issued that read

  logic          gnt0;
  logic          gnt1;
  logic          access;
  logic          cap_hit;
  logic [SW-1:0] own_sel;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;

  assign gnt0      = (state == OWN0);
  assign gnt1      = (state == OWN1);
  assign access    = (gnt0 & bus.req0) | (gnt1 & bus.req1);
  assign cap_hit   = (hold_cnt == HOLD_TOP);
  assign own_sel   = gnt1 ? bus.sel1   : bus.sel0;
  assign own_addr  = gnt1 ? bus.addr1  : bus.addr0;
  assign own_wdata = gnt1 ? bus.wdata1 : bus.wdata0;

  // Memory bus is driven only during an access so idle cycles show all zero.
  assign bus.mce     = access;
  assign bus.maddr   = access ? own_addr  : '0;
  assign bus.msel    = access ? own_sel   : '0;
  assign bus.mdata_w = access ? own_wdata : '0;

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  // Read data is routed by the tag captured at issue time, not by the current
  // owner, so a read issued on the last cycle before a hand-over still
  // returns to its issuer.
  assign bus.rvalid0 = rd_pend & ~rd_tag;
  assign bus.rvalid1 = rd_pend &  rd_tag;
  assign bus.rdata0  = bus.rvalid0 ? bus.mdata_r : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.mdata_r : '0;

  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req0 & bus.req1) state_nxt = last ? OWN0 : OWN1;
        else if (bus.req0)       state_nxt = OWN0;
        else if (bus.req1)       state_nxt = OWN1;
        else                     state_nxt = IDLE;
      end
      OWN0: begin
        // lock holds the grant unless the other port waits and the cap is hit
        if (bus.req0 & bus.lock0 & ~(bus.req1 & cap_hit)) state_nxt = OWN0;
        else if (bus.req1)                                  state_nxt = OWN1;
        else if (bus.req0)                                  state_nxt = OWN0;
        else                                                state_nxt = IDLE;
      end
      OWN1: begin
        if (bus.req1 & bus.lock1 & ~(bus.req0 & cap_hit)) state_nxt = OWN1;
        else if (bus.req0)                                  state_nxt = OWN0;
        else if (bus.req1)                                  state_nxt = OWN1;
        else                                                state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_tag   <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state_nxt != state)        hold_cnt <= '0;
      else if (access && !cap_hit)   hold_cnt <= hold_cnt + 1'b1;

      if (state_nxt == OWN0 && state != OWN0)      last <= 1'b0;
      else if (state_nxt == OWN1 && state != OWN1) last <= 1'b1;

      rd_pend <= access && (own_sel != WR_SEL);
      rd_tag  <= gnt1;
    end
  end

endmodule

// File: tb/tb_rnn_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rnn_mem_arbiter
// Directed bench for rnn_mem_arbiter. Stimulus pushes each expected memory
// access (stamped with the cycle it must appear in) and each expected read
// return into queues; a negedge monitor pops and compares whenever the DUT
// shows mce or rvalid. A small memory model answers reads with a fixed
// function of the address.
// ---------------------------------------------------------------------------
module tb_rnn_mem_arbiter;

  localparam int         AW       = 17;
  localparam int         DW       = 20;
  localparam int         SW       = 3;
  localparam logic [2:0] WR_SEL   = 3'b101;
  localparam int         MAX_HOLD = 64;
  localparam int         ACC_W    = 16 + 1 + SW + AW + DW;
  localparam int         RD_W     = 16 + DW;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  rnn_mem_arbiter_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

  rnn_mem_arbiter #(
    .AW(AW), .DW(DW), .SW(SW), .WR_SEL(WR_SEL), .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [ACC_W-1:0] exp_acc_q[$];
  logic [RD_W-1:0]  exp_rd0_q[$];
  logic [RD_W-1:0]  exp_rd1_q[$];
  int               n_cmp;
  int               n_err;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return 20'h0ABC8 ^ {3'b000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] got);
    n_cmp++;
    n_err++;
    $display("FAIL %s @cyc %0d: got %h with nothing expected", name, cyc, got);
  endtask

  // Records the access the current owner makes this cycle, and its read return.
  task automatic expect_access(input bit own);
    logic [SW-1:0] s;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    logic [15:0]   now;
    logic [15:0]   nxt;
    s   = own ? bus.sel1   : bus.sel0;
    a   = own ? bus.addr1  : bus.addr0;
    w   = own ? bus.wdata1 : bus.wdata0;
    now = 16'(cyc);
    nxt = 16'(cyc + 1);
    exp_acc_q.push_back({now, own, s, a, w});
    if (s != WR_SEL) begin
      if (own) exp_rd1_q.push_back({nxt, mem_f(a)});
      else     exp_rd0_q.push_back({nxt, mem_f(a)});
    end
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctl"}, {bus.gnt0, bus.gnt1, bus.mce, bus.rvalid0, bus.rvalid1,
                         bus.maddr, bus.msel, bus.mdata_w, dbg_state}, 64'd0);
    chk({name, "_rdata"}, {bus.rdata0, bus.rdata1}, 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [ACC_W-1:0] ea;
    logic [RD_W-1:0]  er;
    if (reset) begin
      if (bus.mce) begin
        if (exp_acc_q.size() == 0) unexpected("access", {bus.gnt1, bus.msel, bus.maddr, bus.mdata_w});
        else begin
          ea = exp_acc_q.pop_front();
          chk("access", {16'(cyc), bus.gnt1, bus.msel, bus.maddr, bus.mdata_w}, ea);
        end
      end else begin
        chk("bus_idle", {bus.msel, bus.maddr, bus.mdata_w}, 64'd0);
      end
      if (bus.rvalid0) begin
        if (exp_rd0_q.size() == 0) unexpected("rvalid0", bus.rdata0);
        else begin
          er = exp_rd0_q.pop_front();
          chk("rdata0", {16'(cyc), bus.rdata0}, er);
        end
      end else begin
        chk("rdata0_idle", bus.rdata0, 64'd0);
      end
      if (bus.rvalid1) begin
        if (exp_rd1_q.size() == 0) unexpected("rvalid1", bus.rdata1);
        else begin
          er = exp_rd1_q.pop_front();
          chk("rdata1", {16'(cyc), bus.rdata1}, er);
        end
      end else begin
        chk("rdata1_idle", bus.rdata1, 64'd0);
      end
    end
  end

  // ---------------- memory model ----------------
  // Read data appears after the access cycle's negedge and stays through the
  // next cycle's negedge sample; non-read cycles leave a junk pattern.
  always @(negedge clk) begin
    #2;
    if (bus.mce && bus.msel != WR_SEL) bus.mdata_r = mem_f(bus.maddr);
    else                               bus.mdata_r = 20'h5A5A5;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.req0 = 1'b0; bus.lock0 = 1'b0; bus.sel0 = '0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.lock1 = 1'b0; bus.sel1 = '0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic clear_expect();
    exp_acc_q.delete();
    exp_rd0_q.delete();
    exp_rd1_q.delete();
  endtask

  task automatic do_reset(input string name);
    step();
    reset = 1'b0;
    clear_expect();
    #1;
    check_all_zero(name);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    reset = 1'b0;
    bus.mdata_r = '0;
    set_idle();

    // 1: reset, then idle for 10 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle", {dbg_state, bus.gnt0, bus.gnt1, bus.mce, bus.maddr}, 64'd0);
    end

    // 2: single read by port 0, addr 5 returns 20'h0ABCD
    step();
    bus.req0 = 1'b1; bus.sel0 = 3'b001; bus.addr0 = 17'd5;
    step();
    expect_access(1'b0);
    step();
    bus.req0 = 1'b0;
    step();
    step();

    // 3: tie after reset, no lock -> grants alternate 0,1,0,1...
    do_reset("reset_t3");
    step();
    bus.req0 = 1'b1; bus.sel0 = 3'b001; bus.addr0 = 17'h00100;
    bus.req1 = 1'b1; bus.sel1 = 3'b010; bus.addr1 = 17'h00200;
    for (int i = 1; i <= 6; i++) begin
      step();
      bus.addr0 = 17'(32'h100 + i);
      bus.addr1 = 17'(32'h200 + i);
      expect_access((i % 2) == 0);
    end
    step();
    set_idle();
    step();

    // 4: port 1 write alone, no read return
    step();
    bus.req1 = 1'b1; bus.sel1 = 3'b101; bus.addr1 = 17'h1F040; bus.wdata1 = 20'h10000;
    step();
    expect_access(1'b1);
    step();
    set_idle();
    step();

    // 5: locked burst by port 0, port 1 requests at access 10 -> 64 accesses
    step();
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.sel0 = 3'b001; bus.addr0 = 17'h00300;
    for (int m = 1; m <= MAX_HOLD; m++) begin
      step();
      bus.addr0 = 17'(32'h300 + m);
      if (m == 10) begin
        bus.req1 = 1'b1; bus.sel1 = 3'b010; bus.addr1 = 17'h04000;
      end
      expect_access(1'b0);
    end
    step();
    bus.addr0 = 17'(32'h300 + MAX_HOLD + 1);
    expect_access(1'b1);
    step();
    bus.req1 = 1'b0;
    bus.addr0 = 17'(32'h300 + MAX_HOLD + 2);
    expect_access(1'b0);
    step();
    set_idle();
    step();

    // 6: reset asserted during OWN1 the cycle after a read
    step();
    bus.req1 = 1'b1; bus.sel1 = 3'b011; bus.addr1 = 17'h00055;
    step();
    expect_access(1'b1);
    step();
    bus.req0 = 1'b1; bus.sel0 = 3'b001; bus.addr0 = 17'h00060;
    bus.sel1 = 3'b010; bus.addr1 = 17'h00070;
    reset = 1'b0;
    clear_expect();
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    check_all_zero("reset_held");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
    expect_access(1'b0);
    step();
    expect_access(1'b1);
    step();
    set_idle();
    step();
    step();

    // every expected output must have been seen
    @(negedge clk);
    chk("acc_q_left", 64'(exp_acc_q.size()), 64'd0);
    chk("rd0_q_left", 64'(exp_rd0_q.size()), 64'd0);
    chk("rd1_q_left", 64'(exp_rd1_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
